// File: rtl/fpu_mem_operand_loader.sv
// fpu_mem_operand_loader
//
// Operand-fetch stage for the FPU load path. It reads 2, 4 or 5 consecutive
// little-endian 16-bit words from the bus, starting at a byte address. It
// assembles them into a zero-extended 80-bit operand and presents that operand
// with a one-cycle valid pulse. For FP64 loads the same pulse also enables the
// FP64->FP80 converter, which takes operand[63:0] directly.
//
// Ports
//   clk            clock, rising edge
//   reset_n        asynchronous active-low reset
//   start          load request, sampled only while idle
//   fmt            00: 2 words, 01: 4 words (FP64), 10: 5 words, 11: illegal
//   base_addr      byte address of the least significant word
//   abort          cancels a load that is fetching words
//   mem_req        read request to the bus interface
//   mem_addr       byte address of the word being requested
//   mem_ack        mem_rdata holds the requested word this cycle
//   mem_rdata      read data word
//   operand        assembled operand; held from completion until the next load
//   operand_valid  one-cycle pulse when the operand is complete
//   conv_enable    operand_valid for FP64 loads
//   conv_fp64      operand[63:0]
//   busy           high while fetching words and during the valid cycle
//   error          one-cycle pulse after start with an illegal fmt
module fpu_mem_operand_loader #(
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        fmt,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              abort,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic [79:0]       operand,
  output logic              operand_valid,
  output logic              conv_enable,
  output logic [63:0]       conv_fp64,
  output logic              busy,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] FMT_W2      = 2'b00;
  localparam logic [1:0] FMT_W4      = 2'b01;
  localparam logic [1:0] FMT_ILLEGAL = 2'b11;

  state_t            r_state;
  logic [1:0]        r_fmt;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_cnt;
  logic [79:0]       r_operand;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_valid;
  logic              r_conv_en;
  logic              r_busy;
  logic              r_error;

  logic [2:0]        w_last_cnt;
  logic [2:0]        w_cnt_inc;
  logic [ADDR_W-1:0] w_next_addr;

  // Index of the final word for the latched format.
  always_comb begin
    case (r_fmt)
      FMT_W2:  w_last_cnt = 3'd1;
      FMT_W4:  w_last_cnt = 3'd3;
      default: w_last_cnt = 3'd4;
    endcase
  end

  // The address of the following word is computed ahead of time, so that
  // mem_addr is a register and advances on the same edge that consumes an
  // ack. The sum wraps at ADDR_W bits.
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_next_addr = r_base + ADDR_W'({w_cnt_inc, 1'b0});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_fmt      <= 2'b00;
      r_base     <= '0;
      r_cnt      <= 3'd0;
      r_operand  <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_valid    <= 1'b0;
      r_conv_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      // Pulse outputs default low; they are raised only for one cycle.
      r_valid   <= 1'b0;
      r_conv_en <= 1'b0;
      r_error   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (fmt == FMT_ILLEGAL) begin
              r_error <= 1'b1;
            end else begin
              r_fmt      <= fmt;
              r_base     <= base_addr;
              r_cnt      <= 3'd0;
              r_operand  <= '0;
              r_mem_req  <= 1'b1;
              r_mem_addr <= base_addr;
              r_busy     <= 1'b1;
              r_state    <= S_REQ;
            end
          end
        end

        S_REQ: begin
          if (abort) begin
            // Abort takes priority over a simultaneous ack. That word is dropped.
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else if (mem_ack) begin
            for (int w = 0; w < 5; w++) begin
              if (r_cnt == 3'(w)) begin
                r_operand[16*w +: 16] <= mem_rdata;
              end
            end
            r_cnt <= w_cnt_inc;
            if (r_cnt == w_last_cnt) begin
              r_mem_req  <= 1'b0;
              r_mem_addr <= '0;
              r_valid    <= 1'b1;
              r_conv_en  <= (r_fmt == FMT_W4);
              r_state    <= S_DONE;
            end else begin
              r_mem_addr <= w_next_addr;
            end
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_mem_req  <= 1'b0;
          r_mem_addr <= '0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign operand       = r_operand;
  assign operand_valid = r_valid;
  assign conv_enable   = r_conv_en;
  assign conv_fp64     = r_operand[63:0];
  assign busy          = r_busy;
  assign error         = r_error;

endmodule
